dp_stim_checker: RTL

- Self-checking operand issuer and result checker for the registered signed datapath that computes z = ((a % c) == zero) ? a-1 : c+1.
- Drives a, b, c and zero into that datapath and captures z after the datapath latency.
- Compares each captured z against an internal golden model and reports a pass/fail summary.
- Sits beside the datapath as on-chip BIST.

---
 rtl/dp_stim_pkg.sv | 24 ++
 rtl/dp_stim_checker_if.sv | 28 ++
 rtl/dp_golden_model.sv | 33 +++
 rtl/dp_stim_checker.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dp_stim_pkg.sv
// Shared types and constants for the datapath stimulus/checker BIST block.
// Holds the FSM state type, LFSR feedback mask, default seeds and sentinels.
package dp_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [63:0] LFSR_MASK      = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEFAULT_SEED_A = 64'hACE1_0000_0000_0001;
  localparam logic [63:0] DEFAULT_SEED_C = 64'h1234_5678_9ABC_DEF1;

  localparam logic [15:0] IDX_NONE = 16'hFFFF;
  localparam logic [15:0] ERR_SAT  = 16'hFFFF;

  // One step of the 64-bit right-shifting Galois LFSR.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/dp_stim_checker_if.sv
// Operand/result bus between the BIST checker (master) and the datapath under test (slave).
interface dp_stim_checker_if #(
  parameter int DATAWIDTH = 64
);

  logic [DATAWIDTH-1:0] dut_a;
  logic [DATAWIDTH-1:0] dut_b;
  logic [DATAWIDTH-1:0] dut_c;
  logic [DATAWIDTH-1:0] dut_zero;
  logic [DATAWIDTH-1:0] dut_z;

  modport master (
    output dut_a,
    output dut_b,
    output dut_c,
    output dut_zero,
    input  dut_z
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    input  dut_c,
    input  dut_zero,
    output dut_z
  );

endinterface

// File: rtl/dp_golden_model.sv
// Combinational reference for z = ((a % c) == zero) ? a-1 : c+1 on signed operands.
// Remainder truncates toward zero (sign follows a); c==0 yields g=a.
module dp_golden_model #(
  parameter int DATAWIDTH = 64
) (
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] c_i,
  input  logic [DATAWIDTH-1:0] zero_i,
  output logic [DATAWIDTH-1:0] z_exp_o
);

  localparam logic [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

  logic [DATAWIDTH-1:0] a_mag;
  logic [DATAWIDTH-1:0] c_mag;
  logic [DATAWIDTH-1:0] c_div;
  logic [DATAWIDTH-1:0] r_mag;
  logic [DATAWIDTH-1:0] g;

  // Work on unsigned magnitudes so the most-negative dividend cannot overflow.
  always_comb begin
    a_mag   = a_i[DATAWIDTH-1] ? (~a_i + ONE) : a_i;
    c_mag   = c_i[DATAWIDTH-1] ? (~c_i + ONE) : c_i;
    c_div   = (c_i == '0) ? ONE : c_mag;
    r_mag   = a_mag % c_div;
    g       = a_i[DATAWIDTH-1] ? (~r_mag + ONE) : r_mag;
    if (c_i == '0) begin
      g = a_i;
    end
    z_exp_o = (g == zero_i) ? (a_i - ONE) : (c_i + ONE);
  end

endmodule

// File: rtl/dp_stim_checker.sv
// On-chip BIST: issues LFSR operand vectors to a registered datapath, checks its
// results against dp_golden_model after LATENCY+1 edges, and reports a summary.
module dp_stim_checker
  import dp_stim_pkg::*;
#(
  parameter int          DATAWIDTH   = 64,
  parameter int          LATENCY     = 1,
  parameter int          NUM_VECTORS = 16,
  parameter logic [63:0] SEED_A      = DEFAULT_SEED_A,
  parameter logic [63:0] SEED_C      = DEFAULT_SEED_C
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  dp_stim_checker_if.master        dut_bus,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [15:0]              err_count,
  output logic [15:0]              first_err_idx
);

  localparam logic [15:0]          LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [DATAWIDTH-1:0] ZERO_OP  = '0;

  state_e               state_q;
  logic [63:0]          lfsr_a_q;
  logic [63:0]          lfsr_c_q;
  logic [15:0]          idx_q;
  logic [DATAWIDTH-1:0] dut_a_q;
  logic [DATAWIDTH-1:0] dut_b_q;
  logic [DATAWIDTH-1:0] dut_c_q;
  logic [DATAWIDTH-1:0] dut_zero_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [15:0]          err_count_q;
  logic [15:0]          first_err_idx_q;

  // Expected-result pipe: valid bits are reset, payload is not.
  logic [LATENCY:0]     exp_v_q;
  logic [DATAWIDTH-1:0] exp_z_q   [LATENCY+1];
  logic [15:0]          exp_idx_q [LATENCY+1];

  logic                 start_launch;
  logic                 launch;
  logic [63:0]          src_a;
  logic [63:0]          src_c;
  logic [15:0]          launch_idx;
  logic [DATAWIDTH-1:0] op_a;
  logic [DATAWIDTH-1:0] op_c;
  logic [DATAWIDTH-1:0] z_exp;
  logic                 cmp_valid;
  logic                 mismatch;
  logic                 inflight;
  logic                 last_cmp;
  logic [15:0]          err_count_d;
  logic [15:0]          first_err_idx_d;

  dp_golden_model #(
    .DATAWIDTH (DATAWIDTH)
  ) u_golden (
    .a_i     (op_a),
    .c_i     (op_c),
    .zero_i  (ZERO_OP),
    .z_exp_o (z_exp)
  );

  // A start from IDLE/DONE launches vector 0 straight from the seeds.
  always_comb begin
    start_launch = start && ((state_q == IDLE) || (state_q == DONE));
    launch       = start_launch || (state_q == ISSUE);
    src_a        = start_launch ? SEED_A : lfsr_a_q;
    src_c        = start_launch ? SEED_C : lfsr_c_q;
    launch_idx   = start_launch ? 16'd0 : idx_q;
    op_a         = src_a[DATAWIDTH-1:0];
    op_c         = src_c[DATAWIDTH-1:0];
    op_c[0]      = 1'b1;
  end

  always_comb begin
    cmp_valid       = exp_v_q[LATENCY];
    mismatch        = cmp_valid && (dut_bus.dut_z != exp_z_q[LATENCY]);
    inflight        = |exp_v_q[LATENCY-1:0];
    last_cmp        = cmp_valid && !inflight && (state_q == DRAIN);
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    if (mismatch) begin
      if (err_count_q != ERR_SAT) begin
        err_count_d = err_count_q + 16'd1;
      end
      if (first_err_idx_q == IDX_NONE) begin
        first_err_idx_d = exp_idx_q[LATENCY];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      lfsr_a_q        <= SEED_A;
      lfsr_c_q        <= SEED_C;
      idx_q           <= '0;
      dut_a_q         <= '0;
      dut_b_q         <= '0;
      dut_c_q         <= '0;
      dut_zero_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_count_q     <= '0;
      first_err_idx_q <= IDX_NONE;
      exp_v_q         <= '0;
    end else begin
      exp_v_q         <= {exp_v_q[LATENCY-1:0], launch};
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      dut_b_q         <= '0;
      dut_zero_q      <= '0;
      if (launch) begin
        dut_a_q  <= op_a;
        dut_c_q  <= op_c;
        lfsr_a_q <= lfsr_step(src_a);
        lfsr_c_q <= lfsr_step(src_c);
        idx_q    <= launch_idx + 16'd1;
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (NUM_VECTORS == 1) begin
              state_q <= DRAIN;
            end else begin
              state_q <= ISSUE;
            end
            busy_q          <= 1'b1;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_count_q     <= '0;
            first_err_idx_q <= IDX_NONE;
          end
        end
        ISSUE: begin
          if (idx_q == LAST_IDX) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_cmp) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == 16'd0);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    exp_z_q[0]   <= z_exp;
    exp_idx_q[0] <= launch_idx;
    for (int k = 1; k <= LATENCY; k++) begin
      exp_z_q[k]   <= exp_z_q[k-1];
      exp_idx_q[k] <= exp_idx_q[k-1];
    end
  end

  assign dut_bus.dut_a    = dut_a_q;
  assign dut_bus.dut_b    = dut_b_q;
  assign dut_bus.dut_c    = dut_c_q;
  assign dut_bus.dut_zero = dut_zero_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_count_q;
  assign first_err_idx    = first_err_idx_q;

endmodule
